// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, defaults and SPI mode helpers
// for the SPI transfer sequencer.
package spi_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DIVW_DEF  = 8;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LEAD,
    SHIFT,
    TRAIL,
    GAP
  } state_t;

  function automatic logic mode_cpol(
    input logic [1:0] m
  );
    return (m == MODE2) || (m == MODE3);
  endfunction

  function automatic logic mode_cpha(
    input logic [1:0] m
  );
    return (m == MODE1) || (m == MODE3);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period tick generator, one tick every
// BaudDiv+1 cycles; clear restarts the count from zero.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int DIVW = DIVW_DEF
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            clear,
  input  logic [DIVW-1:0] BaudDiv,
  output logic            tick
);

  logic [DIVW-1:0] cnt;

  assign tick = (cnt == BaudDiv);

  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: pops a TX word, shifts it out MSB first on the
// SPI pins while capturing MISO, and pushes the result to RX.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIVW  = DIVW_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             CPOL,
  input  logic             CPHA,
  input  logic [DIVW-1:0]  BaudDiv,
  input  logic [4:0]       WordSize,
  input  logic             TxEmpty,
  input  logic [WIDTH-1:0] TxData,
  output logic             TxRead,
  input  logic             RxFull,
  output logic [WIDTH-1:0] RxData,
  output logic             RxWrite,
  input  logic             ClearRxOV,
  output logic             RxOverrun,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO,
  output logic             CS_n,
  output logic             Busy
);

  state_t           state;
  logic [1:0]       mode_q;
  logic [DIVW-1:0]  div_q;
  logic [4:0]       ws_q;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] rx;
  logic [5:0]       ecnt;
  logic             tick;
  logic             lead_e;
  logic             last_e;
  logic             samp_e;

  assign lead_e = ~ecnt[0];
  assign last_e = (ecnt == {ws_q, 1'b1});
  assign samp_e = lead_e ^ mode_cpha(mode_q);

  spi_clk_div #(.DIVW(DIVW)) u_div (
    .Clock   (Clock),
    .Reset   (Reset),
    .clear   (state == LOAD),
    .BaudDiv (div_q),
    .tick    (tick)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      mode_q    <= MODE0;
      div_q     <= '0;
      ws_q      <= '0;
      sr        <= '0;
      rx        <= '0;
      ecnt      <= '0;
      TxRead    <= 1'b0;
      RxWrite   <= 1'b0;
      RxData    <= '0;
      RxOverrun <= 1'b0;
      SCLK      <= 1'b0;
      MOSI      <= 1'b0;
      CS_n      <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      TxRead  <= 1'b0;
      RxWrite <= 1'b0;
      // a same-cycle overrun below overrides the clear
      if (ClearRxOV) RxOverrun <= 1'b0;
      unique case (state)
        IDLE: begin
          SCLK <= CPOL;
          CS_n <= 1'b1;
          if (Enable && !TxEmpty) begin
            state  <= LOAD;
            TxRead <= 1'b1;
            Busy   <= 1'b1;
          end
        end
        LOAD: begin
          mode_q <= {CPOL, CPHA};
          div_q  <= BaudDiv;
          ws_q   <= WordSize;
          SCLK   <= CPOL;
          CS_n   <= 1'b0;
          rx     <= '0;
          ecnt   <= '0;
          if (CPHA) begin
            sr <= TxData;
          end else begin
            MOSI <= TxData[WordSize];
            sr   <= {TxData[WIDTH-2:0], 1'b0};
          end
          state <= LEAD;
        end
        LEAD: begin
          if (tick) state <= SHIFT;
        end
        SHIFT: begin
          if (tick) begin
            SCLK <= ~SCLK;
            ecnt <= ecnt + 6'd1;
            if (samp_e) begin
              rx <= {rx[WIDTH-2:0], MISO};
            end else if (!last_e) begin
              MOSI <= sr[ws_q];
              sr   <= {sr[WIDTH-2:0], 1'b0};
            end
            if (last_e) begin
              SCLK  <= mode_cpol(mode_q);
              state <= TRAIL;
            end
          end
        end
        TRAIL: begin
          if (tick) begin
            CS_n <= 1'b1;
            if (!RxFull) begin
              RxWrite <= 1'b1;
              RxData  <= rx;
            end else begin
              RxOverrun <= 1'b1;
            end
            state <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: directed vectors with a scoreboard of expected
// RX words checked by a monitor on every RxWrite.
module tb_spi_xfer_ctrl;
  import spi_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic        CPOL = 1'b0;
  logic        CPHA = 1'b0;
  logic [7:0]  BaudDiv = 8'd0;
  logic [4:0]  WordSize = 5'd7;
  logic        TxEmpty = 1'b1;
  logic [31:0] TxData = 32'h0;
  logic        TxRead;
  logic        RxFull = 1'b0;
  logic [31:0] RxData;
  logic        RxWrite;
  logic        ClearRxOV = 1'b0;
  logic        RxOverrun;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic        CS_n;
  logic        Busy;

  assign MISO = MOSI;

  spi_xfer_ctrl dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Enable    (Enable),
    .CPOL      (CPOL),
    .CPHA      (CPHA),
    .BaudDiv   (BaudDiv),
    .WordSize  (WordSize),
    .TxEmpty   (TxEmpty),
    .TxData    (TxData),
    .TxRead    (TxRead),
    .RxFull    (RxFull),
    .RxData    (RxData),
    .RxWrite   (RxWrite),
    .ClearRxOV (ClearRxOV),
    .RxOverrun (RxOverrun),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .CS_n      (CS_n),
    .Busy      (Busy)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad = 0;

  logic [31:0] txq[$];
  logic [31:0] sbq[$];

  int n_txrd, n_rxwr, busy_cyc, sclk_rise;
  int mosi_bad, cs_min, cs_run;
  bit seen_low, chk_mosi;
  logic prev_sclk = 1'b0;
  logic prev_mosi = 1'b0;
  logic prev_cs = 1'b1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // registered-head TX FIFO model
  always @(posedge Clock) begin
    if (TxRead && txq.size() > 0) void'(txq.pop_front());
    TxEmpty <= (txq.size() == 0);
    TxData  <= (txq.size() > 0) ? txq[0] : 32'h0;
  end

  always @(negedge Clock) begin
    if (!Reset) begin
      if (TxRead) begin
        n_txrd++;
        chk("pop_when_empty", {31'd0, TxEmpty}, 32'd0);
      end
      if (RxWrite) begin
        n_rxwr++;
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got %0h want none", RxData);
        end else begin
          chk("rxdata", RxData, sbq.pop_front());
        end
      end
      if (Busy) busy_cyc++;
      if (!CS_n && !prev_sclk && SCLK) sclk_rise++;
      if (chk_mosi && MOSI != prev_mosi &&
          !(prev_sclk && !SCLK)) mosi_bad++;
      if (CS_n) begin
        cs_run++;
      end else begin
        if (prev_cs && seen_low && cs_run < cs_min)
          cs_min = cs_run;
        cs_run = 0;
        seen_low = 1'b1;
      end
    end
    prev_sclk = SCLK;
    prev_mosi = MOSI;
    prev_cs = CS_n;
  end

  task automatic tick1();
    @(posedge Clock);
    #1;
  endtask

  task automatic clr_counts();
    n_txrd = 0;
    n_rxwr = 0;
    busy_cyc = 0;
    sclk_rise = 0;
    mosi_bad = 0;
    cs_min = 1000;
    cs_run = 0;
    seen_low = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] m,
                     input logic [7:0] bd,
                     input logic [4:0] ws);
    {CPOL, CPHA} = m;
    BaudDiv = bd;
    WordSize = ws;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!Busy && n < 20) begin
      tick1();
      n++;
    end
    chk({nm, "_started"}, {31'd0, Busy}, 32'd1);
    while (Busy && n < 3000) begin
      tick1();
      n++;
    end
    chk({nm, "_ended"}, {31'd0, Busy}, 32'd0);
  endtask

  task automatic wait_shift(input string nm);
    int n = 0;
    while (!(SCLK && !CS_n) && n < 500) begin
      tick1();
      n++;
    end
    chk({nm, "_in_shift"}, {31'd0, SCLK && !CS_n}, 32'd1);
  endtask

  initial begin
    clr_counts();
    repeat (3) tick1();
    chk("reset_out",
        {25'd0, TxRead, RxWrite, RxOverrun, SCLK, MOSI, CS_n, Busy},
        32'b0000010);
    chk("reset_rxdata", RxData, 32'h0);
    Reset = 1'b0;
    tick1();

    // mode 0, 8 bits, H=2
    cfg(MODE0, 8'd1, 5'd7);
    clr_counts();
    txq.push_back(32'h0000_00A5);
    sbq.push_back(32'h0000_00A5);
    Enable = 1'b1;
    wait_done("m0");
    Enable = 1'b0;
    tick1();
    chk("m0_txread", n_txrd, 1);
    chk("m0_rxwrite", n_rxwr, 1);
    chk("m0_latency", busy_cyc, 39);
    chk("m0_rises", sclk_rise, 8);

    // mode 2, 12 bits, upper TX bits ignored, H=4
    cfg(MODE2, 8'd3, 5'd11);
    clr_counts();
    txq.push_back(32'hFFFF_F123);
    sbq.push_back(32'h0000_0123);
    Enable = 1'b1;
    wait_done("m2");
    Enable = 1'b0;
    tick1();
    chk("m2_latency", busy_cyc, 109);
    chk("m2_sclk_idle", {31'd0, SCLK}, 32'd1);

    // mode 3, 32 bits, H=1
    cfg(MODE3, 8'd0, 5'd31);
    tick1();
    clr_counts();
    chk_mosi = 1'b1;
    txq.push_back(32'hDEAD_BEEF);
    sbq.push_back(32'hDEAD_BEEF);
    Enable = 1'b1;
    wait_done("m3");
    Enable = 1'b0;
    tick1();
    chk_mosi = 1'b0;
    chk("m3_latency", busy_cyc, 68);
    chk("m3_mosi_edge", mosi_bad, 0);
    chk("m3_sclk_idle", {31'd0, SCLK}, 32'd1);

    // overrun, then clear, then clear colliding with set
    cfg(MODE0, 8'd0, 5'd7);
    clr_counts();
    RxFull = 1'b1;
    txq.push_back(32'h0000_003C);
    Enable = 1'b1;
    wait_done("ov1");
    Enable = 1'b0;
    tick1();
    chk("ov1_no_push", n_rxwr, 0);
    chk("ov1_set", {31'd0, RxOverrun}, 32'd1);
    ClearRxOV = 1'b1;
    tick1();
    ClearRxOV = 1'b0;
    chk("ov_cleared", {31'd0, RxOverrun}, 32'd0);
    txq.push_back(32'h0000_003C);
    ClearRxOV = 1'b1;
    Enable = 1'b1;
    wait_shift("ov2");
    for (int i = 0; i < 500 && !CS_n; i++) tick1();
    ClearRxOV = 1'b0;
    chk("ov2_set_wins", {31'd0, RxOverrun}, 32'd1);
    wait_done("ov2");
    Enable = 1'b0;
    RxFull = 1'b0;
    tick1();
    chk("ov2_no_push", n_rxwr, 0);

    // three back-to-back words, H=3
    cfg(MODE1, 8'd2, 5'd7);
    clr_counts();
    txq.push_back(32'h11);
    txq.push_back(32'h22);
    txq.push_back(32'h33);
    sbq.push_back(32'h11);
    sbq.push_back(32'h22);
    sbq.push_back(32'h33);
    Enable = 1'b1;
    for (int i = 0; i < 1000 && n_rxwr < 3; i++) tick1();
    wait_done("b3");
    Enable = 1'b0;
    tick1();
    chk("b3_txread", n_txrd, 3);
    chk("b3_rxwrite", n_rxwr, 3);
    chk("b3_busy_cyc", busy_cyc, 174);
    chk("b3_cs_gap", {31'd0, cs_min >= 5}, 32'd1);
    chk("b3_busy_low", {31'd0, Busy}, 32'd0);

    // Enable dropped mid-word
    cfg(MODE0, 8'd1, 5'd7);
    clr_counts();
    txq.push_back(32'h5A);
    txq.push_back(32'h77);
    sbq.push_back(32'h5A);
    Enable = 1'b1;
    wait_shift("en");
    Enable = 1'b0;
    wait_done("en");
    repeat (5) tick1();
    chk("en_txread", n_txrd, 1);
    chk("en_rxwrite", n_rxwr, 1);
    chk("en_latency", busy_cyc, 39);
    chk("en_txempty", {31'd0, TxEmpty}, 32'd0);
    txq.delete();
    repeat (2) tick1();

    // reset in the middle of SHIFT; overrun is still set here
    clr_counts();
    txq.push_back(32'h99);
    Enable = 1'b1;
    wait_shift("rst");
    Enable = 1'b0;
    Reset = 1'b1;
    tick1();
    chk("rst_out", {28'd0, CS_n, SCLK, Busy, RxOverrun}, 32'b1000);
    Reset = 1'b0;
    repeat (60) tick1();
    chk("rst_no_push", n_rxwr, 0);
    chk("rst_idle", {31'd0, Busy}, 32'd0);
    chk("sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
